mul_sequencer: RTL
==================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: Start  input  1  execute-stage request to begin a multiply.
REQ-004 SHALL have port: SrcA  input  32  multiplicand (Rm).
REQ-005 SHALL have port: SrcB  input  32  multiplier (Rs).
REQ-006 SHALL have port: Accumulate  input  1  MLA select; add AccIn to the product.
REQ-007 SHALL have port: AccIn  input  32  accumulate operand (Rn).
REQ-008 SHALL have port: Flush  input  1  cancel the operation in flight.
REQ-009 SHALL have port: Stall  output  1  holds the F, D and E pipeline stages.
REQ-010 SHALL have port: Busy  output  1  high in the RUN state.
REQ-011 SHALL have port: Done  output  1  one-cycle result-valid pulse.
REQ-012 SHALL have port: Result  output  32  low product word.
REQ-013 SHALL have port: ResultHi  output  32  high product word (see REQ-029).
REQ-014 SHALL have port: MulFlags  output  2  {N,Z} of the final result.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 IDLE transitions:
- Start=1 and Flush=0: load operands, set count=0, go to RUN.
- Otherwise: stay in IDLE.
REQ-017 RUN, each cycle:
- If SrcB-copy bit[count]=1, add (SrcA-copy << count) into the accumulator.
- Increment count.
- After the cycle in which count=31, go to DONE.
REQ-018 DONE SHALL hold one cycle with Done=1, then go to IDLE.
REQ-019 Latency:
- Start sampled in cycle 0.
- RUN occupies cycles 1-32.
- Done=1 in cycle 33.
REQ-020 Accumulator initial value:
- AccIn when Accumulate=1.
- Zero when Accumulate=0.
- Result = (SrcA*SrcB + AccIn) mod 2^32.
REQ-021 Stall SHALL equal (IDLE & Start & ~Flush) | RUN, combinationally.
- Stall is low in DONE so the pipeline advances with Result.
REQ-022 Result, ResultHi and MulFlags SHALL:
- Update only on entry to DONE.
- Hold their value until the next DONE.
REQ-023 MulFlags SHALL be:
- N = MSB of the result.
- Z = 1 when the whole result is zero.
REQ-024 Start during RUN or DONE SHALL be ignored; no queuing.
REQ-025 Flush during RUN SHALL:
- Return the FSM to IDLE on the next edge.
- Suppress Done.
- Leave Result unchanged.
REQ-026 Flush during DONE SHALL NOT suppress the Done pulse already asserted.
REQ-027 Start and Flush both high in IDLE: Flush wins; stay in IDLE.

Reset
REQ-028 On reset low, asynchronously:
- FSM to IDLE and count to 0.
- Stall, Busy, Done = 0.
- Result, ResultHi = 0.
- MulFlags = 2'b00.
- Reset mid-RUN aborts the operation with no Done.

Configuration
REQ-029 Macro LONG_MUL_EN:
- Defined: 64-bit accumulator; ResultHi = product bits 63:32 (UMULL semantics, Accumulate adds AccIn to the low word only); N = bit 63; Z over all 64 bits.
- Undefined: 32-bit accumulator; ResultHi tied to 0; N = bit 31; Z over 32 bits.

Structure
REQ-030 Shared package mul_pkg SHALL hold:
- The state encoding (IDLE, RUN, DONE).
- MUL_CYCLES = 32.
- The count width, 5.
REQ-031 Sub-module mul_datapath SHALL hold the operand, accumulator and shift-add registers.
- The FSM, count and Stall logic remain in mul_sequencer.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- SrcA=3, SrcB=5, Accumulate=0, Start pulse -> Stall high cycles 0-32; Done in cycle 33; Result=15; MulFlags=00.
- SrcA=7, SrcB=6, AccIn=100, Accumulate=1 -> Result=142.
- SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> Result=0x00000001 and N=0; ResultHi=0xFFFFFFFE and N=1 with LONG_MUL_EN; ResultHi=0 without it.
- SrcA=0, SrcB=9 -> Result=0, Z=1.
- Flush in RUN cycle 10 -> IDLE next edge; no Done; previous Result held; a new Start then completes normally.
- Start re-asserted during RUN, then reset low mid-RUN -> no second operation; all outputs 0 asynchronously; IDLE after release.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Define LONG_MUL_EN to build a 64-bit accumulator that also produces a high result word.
package mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_e;

    localparam int MUL_CYCLES = 32;
    localparam int CNT_W      = 5;

`ifdef LONG_MUL_EN
    localparam int ACC_W = 64;
`else
    localparam int ACC_W = 32;
`endif

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MUL_CYCLES - 1);

endpackage

// File: rtl/mul_datapath.sv
// Operand, accumulator and result registers for the shift-add multiplier.
// The high result word exists only when LONG_MUL_EN is defined.
module mul_datapath
    import mul_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             commit,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      src_a,
    input  logic [31:0]      src_b,
    input  logic             accumulate,
    input  logic [31:0]      acc_in,
    output logic [31:0]      result,
    output logic [31:0]      result_hi,
    output logic [1:0]       mul_flags
);

    logic [ACC_W-1:0] a_q, a_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] partial;
    logic [31:0]      b_q, b_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic [1:0]       flags_q, flags_d;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        res_lo_d = res_lo_q;
        flags_d  = flags_q;
        partial  = b_q[count] ? (a_q << count) : '0;
        if (load) begin
            a_d   = ACC_W'(src_a);
            b_d   = src_b;
            acc_d = accumulate ? ACC_W'(acc_in) : '0;
        end else if (step) begin
            acc_d = acc_q + partial;
        end
        // commit coincides with the final step, so acc_d already holds the full sum
        if (commit) begin
            res_lo_d = acc_d[31:0];
            flags_d  = {acc_d[ACC_W-1], ~|acc_d};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            res_lo_q <= '0;
            flags_q  <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            res_lo_q <= res_lo_d;
            flags_q  <= flags_d;
        end
    end

`ifdef LONG_MUL_EN
    logic [31:0] res_hi_q, res_hi_d;

    always_comb begin
        res_hi_d = res_hi_q;
        if (commit) res_hi_d = acc_d[63:32];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) res_hi_q <= '0;
        else        res_hi_q <= res_hi_d;
    end

    assign result_hi = res_hi_q;
`else
    assign result_hi = '0;
`endif

    assign result    = res_lo_q;
    assign mul_flags = flags_q;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply sequencer: IDLE/RUN/DONE control, bit counter and pipeline stall.
// Define LONG_MUL_EN for the 64-bit (UMULL-style) result; the default build is 32-bit.
module mul_sequencer
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        Accumulate,
    input  logic [31:0] AccIn,
    input  logic        Flush,
    output logic        Stall,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic [31:0] ResultHi,
    output logic [1:0]  MulFlags,
    output logic [1:0]  state_dbg
);

    // Start is accepted only in IDLE with Flush low; Stall holds F/D/E from that
    // cycle through RUN and drops in DONE so the stage advances with Result.
    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             load, step, commit;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start && !Flush) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (Flush) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else begin
                    step    = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_COUNT) begin
                        commit  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Gated by reset so Stall is low while reset is held even if Start is high.
    assign Stall     = reset & (((state_q == S_IDLE) & Start & ~Flush) | (state_q == S_RUN));
    assign Busy      = (state_q == S_RUN);
    assign Done      = (state_q == S_DONE);
    assign state_dbg = state_q;

    mul_datapath u_datapath (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .commit     (commit),
        .count      (count_q),
        .src_a      (SrcA),
        .src_b      (SrcB),
        .accumulate (Accumulate),
        .acc_in     (AccIn),
        .result     (Result),
        .result_hi  (ResultHi),
        .mul_flags  (MulFlags)
    );

endmodule
